spi_cfg_regfile: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_cfg_regfile.sv | 156 +++++++++++++++
 tb/tb_spi_cfg_regfile.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration register bank.
package spi_cfg_pkg;
  localparam int CMD_W_BIT    = 7;
  localparam int CMD_IMM_BIT  = 6;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_W   = 6;

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;

  localparam logic [255:0] DEFAULT_RESET_CFG = {224'h0, 32'h80FC_0000};
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with rise/fall event pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Events are acted on at the third clk edge after the pin changes.
  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI-slave config register bank with shadow/active copies committed at frame start.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_WIDTH = 32,
  parameter int ADDR_W    = 3,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_CFG =
    (NUM_REGS*REG_WIDTH)'(DEFAULT_RESET_CFG)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          sclk,
  input  logic                          ss_n,
  input  logic                          mosi,
  output logic                          miso,
  input  logic                          frame_start,
  output logic [NUM_REGS*REG_WIDTH-1:0] cfg_active,
  output logic [NUM_REGS-1:0]           cfg_pending,
  output logic                          busy
);
  localparam int CNT_W = $clog2(REG_WIDTH);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .din(ss_n), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi), .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_ok;
  assign unused_ok = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [REG_WIDTH-2:0]        in_sr;
  logic [REG_WIDTH-1:0]        out_sr;
  logic                        miso_q;
  logic                        cmd_w_q, cmd_imm_q;
  logic [CMD_ADDR_W-1:0]       addr_q, addr_next;
  logic [REG_WIDTH-1:0]        word_in;
  logic [7:0]                  cmd_byte;
  logic                        word_done, wr_en;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] act_q;
  logic [NUM_REGS-1:0]         pend_q;

  assign word_in   = {in_sr, mosi_lvl};
  assign cmd_byte  = word_in[7:0];
  assign addr_next = (int'(addr_q) == NUM_REGS-1) ? '0 : addr_q + 1'b1;

  // Out-of-range addresses use the full 6-bit field and read as zero.
  function automatic logic [REG_WIDTH-1:0] rd_word(input logic [CMD_ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) ? act_q[a[ADDR_W-1:0]] : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ena || ss_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (sclk_rise && cnt_q == CNT_W'(7)) state_d = DATA;
        default: ;
      endcase
    end
  end

  assign word_done = (state_q == DATA) && (state_d == DATA) && sclk_rise &&
                     (cnt_q == CNT_W'(REG_WIDTH-1));
  assign wr_en     = word_done && cmd_w_q && (int'(addr_q) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      miso_q    <= 1'b0;
      cmd_w_q   <= 1'b0;
      cmd_imm_q <= 1'b0;
      addr_q    <= '0;
    end else if (state_q == IDLE || state_d == IDLE) begin
      cnt_q  <= '0;
      miso_q <= 1'b0;
    end else if (sclk_rise) begin
      in_sr <= word_in[REG_WIDTH-2:0];
      if (state_q == CMD) begin
        if (cnt_q == CNT_W'(7)) begin
          cnt_q     <= '0;
          cmd_w_q   <= cmd_byte[CMD_W_BIT];
          cmd_imm_q <= cmd_byte[CMD_IMM_BIT];
          addr_q    <= cmd_byte[CMD_ADDR_LSB +: CMD_ADDR_W];
          out_sr    <= rd_word(cmd_byte[CMD_ADDR_LSB +: CMD_ADDR_W]);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (cnt_q == CNT_W'(REG_WIDTH-1)) begin
        cnt_q  <= '0;
        addr_q <= addr_next;
        out_sr <= rd_word(addr_next);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (sclk_fall && state_q == DATA) begin
      miso_q <= ~cmd_w_q & out_sr[REG_WIDTH-1];
      out_sr <= out_sr << 1;
    end
  end

  // Per-register shadow/active pair; a write on the frame clk is applied after
  // the commit so it stays pending, except an immediate write which wins.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [REG_WIDTH-1:0] sh, act;
    logic                 pend, hit;
    assign hit = wr_en && (int'(addr_q) == i);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sh   <= RESET_CFG[i*REG_WIDTH +: REG_WIDTH];
        act  <= RESET_CFG[i*REG_WIDTH +: REG_WIDTH];
        pend <= 1'b0;
      end else begin
        if (frame_start && pend) begin
          act  <= sh;
          pend <= 1'b0;
        end
        if (hit) begin
          sh <= word_in;
          if (cmd_imm_q) begin
            act  <= word_in;
            pend <= 1'b0;
          end else begin
            pend <= 1'b1;
          end
        end
      end
    end

    assign act_q[i]  = act;
    assign pend_q[i] = pend;
  end

  assign cfg_active  = act_q;
  assign cfg_pending = pend_q;
  assign busy        = (state_q != IDLE);
  assign miso        = miso_q & ena & ~ss_lvl;
endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Self-checking bench: vector table of SPI transactions plus corner-case sequences.
module tb_spi_cfg_regfile;
  localparam int HALF = 4;

  logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic         sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0, frame_start = 1'b0;
  logic         miso, busy;
  logic [255:0] cfg_active;
  logic [7:0]   cfg_pending;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  spi_cfg_regfile dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .frame_start(frame_start), .cfg_active(cfg_active),
    .cfg_pending(cfg_pending), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    int          nw;
    logic [31:0] d0, d1;
    bit          fs;
    bit          en;
    int          ridx;
    logic [31:0] exp_act;
    logic [7:0]  exp_pend;
  } vec_t;
  vec_t tv[12];

  function automatic logic [31:0] act_reg(input int i);
    return cfg_active[i*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic sb_check(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty got=%0h exp=none", got);
    end else begin
      chk("read_word", 256'(got), 256'(exp_q.pop_front()));
    end
  endtask

  task automatic spi_bit(input logic b, output logic so);
    mosi = b;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    so = miso;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int nw, input logic [31:0] d0, d1);
    logic [31:0] w, got;
    logic so;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], so);
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? d0 : d1;
      got = '0;
      for (int i = 31; i >= 0; i--) begin
        spi_bit(w[i], so);
        got[i] = so;
      end
      if (!cmd[7]) sb_check(got);
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_pulse();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  // Sends command and all but the final data bit; leaves sclk low.
  task automatic spi_head(input logic [7:0] cmd, input logic [31:0] w);
    logic so;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], so);
    for (int i = 31; i >= 1; i--) spi_bit(w[i], so);
  endtask

  task automatic spi_tail();
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic so;
    tv[0]  = '{8'h00, 1, 32'h80FC0000, 32'h0,        1'b0, 1'b1, 0, 32'h80FC0000, 8'h00};
    tv[1]  = '{8'h0A, 1, 32'h00000000, 32'h0,        1'b0, 1'b1, 0, 32'h80FC0000, 8'h00};
    tv[2]  = '{8'h82, 1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 2, 32'h00000000, 8'h04};
    tv[3]  = '{8'h00, 0, 32'h0,        32'h0,        1'b1, 1'b1, 2, 32'hDEADBEEF, 8'h00};
    tv[4]  = '{8'h87, 2, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 7, 32'h00000000, 8'h81};
    tv[5]  = '{8'h00, 0, 32'h0,        32'h0,        1'b1, 1'b1, 7, 32'h11111111, 8'h00};
    tv[6]  = '{8'h07, 2, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 0, 32'h22222222, 8'h00};
    tv[7]  = '{8'hC5, 1, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 5, 32'hCAFEF00D, 8'h00};
    tv[8]  = '{8'h84, 1, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b1, 4, 32'h00000000, 8'h10};
    tv[9]  = '{8'hC6, 1, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 6, 32'h00000000, 8'h10};
    tv[10] = '{8'h00, 0, 32'h0,        32'h0,        1'b1, 1'b0, 4, 32'hA5A5A5A5, 8'h00};
    tv[11] = '{8'h04, 2, 32'hA5A5A5A5, 32'hCAFEF00D, 1'b0, 1'b1, 4, 32'hA5A5A5A5, 8'h00};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_active", cfg_active, {224'h0, 32'h80FC0000});
    chk("rst_pending", 256'(cfg_pending), 256'h0);
    chk("rst_miso", 256'(miso), 256'h0);
    chk("rst_busy", 256'(busy), 256'h0);

    for (int v = 0; v < 12; v++) begin
      ena = tv[v].en;
      if (tv[v].nw > 0) begin
        if (!tv[v].cmd[7]) begin
          exp_q.push_back(tv[v].d0);
          if (tv[v].nw > 1) exp_q.push_back(tv[v].d1);
        end
        spi_xfer(tv[v].cmd, tv[v].nw, tv[v].d0, tv[v].d1);
      end
      if (tv[v].fs) frame_pulse();
      chk($sformatf("vec%0d_active", v), 256'(act_reg(tv[v].ridx)), 256'(tv[v].exp_act));
      chk($sformatf("vec%0d_pending", v), 256'(cfg_pending), 256'(tv[v].exp_pend));
      ena = 1'b1;
    end

    // Immediate write latency from the final sclk pin rise.
    spi_head(8'hC1, 32'h12345678);
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    lat = 0;
    while (lat < 6 && act_reg(1) !== 32'h12345678) begin
      @(negedge clk);
      lat++;
    end
    chk("imm_latency_ok", 256'(lat <= 4), 256'(1));
    chk("imm_active", 256'(act_reg(1)), 256'h12345678);
    chk("imm_pending", 256'(cfg_pending[1]), 256'h0);
    spi_tail();

    // Partial word aborted by ss_n rise.
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(((8'h83 >> i) & 8'h1) != 0, so);
    for (int i = 0; i < 16; i++) spi_bit(1'b1, so);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy_2clk", 256'(busy), 256'h1);
    @(negedge clk);
    chk("abort_busy_3clk", 256'(busy), 256'h0);
    chk("abort_active", 256'(act_reg(3)), 256'h0);
    chk("abort_pending", 256'(cfg_pending), 256'h0);
    frame_pulse();
    chk("abort_after_frame", 256'(act_reg(3)), 256'h0);

    // Deferred write completing on the frame_start clk.
    spi_xfer(8'h82, 1, 32'hAAAA0001, 32'h0);
    chk("coll_pre_pending", 256'(cfg_pending), 256'h04);
    spi_head(8'h82, 32'h5555AAAA);
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("coll_active", 256'(act_reg(2)), 256'hAAAA0001);
    chk("coll_pending", 256'(cfg_pending), 256'h04);
    spi_tail();
    chk("coll_hold", 256'(act_reg(2)), 256'hAAAA0001);
    frame_pulse();
    chk("coll_commit", 256'(act_reg(2)), 256'h5555AAAA);
    chk("coll_clear", 256'(cfg_pending), 256'h0);

    chk("sb_drained", 256'(exp_q.size()), 256'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
